// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus SRAM responder: accepts one request, answers with data_ok
// a fixed LATENCY cycles later, and performs byte-strobed writes on the response edge.
package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LANES-1:0]   strb_q, strb_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        mem_q [MEM_WORDS];
    logic [31:0]        rdata_q;

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_en;
    logic               mem_we;
    logic               is_write;

    // Only the word index is meaningful; byte offset, size and high bits alias away.
    assign req_idx  = dreq.addr[IDX_W+1:2];
    assign is_write = (strb_q != '0);

    logic unused_bits;
    assign unused_bits = ^{dreq.size, dreq.addr[1:0], dreq.addr[31:IDX_W+2]};

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and response decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        dresp   = '0;

        case (state_q)
            IDLE: begin
                dresp.addr_ok = dreq.valid;
                if (dreq.valid) begin
                    idx_d   = req_idx;
                    strb_d  = dreq.strobe;
                    wdata_d = dreq.data;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                dresp.data_ok = 1'b1;
                dresp.data    = is_write ? 32'h0 : rdata_q;
                mem_we        = is_write;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset silences the bus and suppresses the write of an in-flight transaction.
        if (reset) begin
            dresp  = '0;
            mem_we = 1'b0;
        end
    end

    // Read the word on the edge that enters RESP; from IDLE the index is still on the bus.
    assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
    assign rd_en  = (state_d == RESP) && (state_q != RESP);

    // Storage array: not reset, byte-lane writes on the response edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (strb_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata_q <= mem_q[rd_idx];
        end
    end

endmodule
